clk_set_ctrl: RTL

//  Front-panel setting controller for the real-time clock.

---
 rtl/clk_pkg.sv | 30 +++
 rtl/clk_set_ctrl_if.sv | 30 +++
 rtl/clk_set_ctrl_wrap_updown_cnt.sv | 33 +++
 rtl/clk_set_ctrl.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/clk_pkg.sv
// Shared constants for the clock-setting controller: field addresses,
// field limits, data width and the edit FSM state encoding.
package clk_pkg;

    localparam int DATA_W   = 6;
    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;

    localparam logic [1:0] ADDR_SEC  = 2'b00;
    localparam logic [1:0] ADDR_MIN  = 2'b01;
    localparam logic [1:0] ADDR_HOUR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EDIT_H = 2'd1,
        ST_EDIT_M = 2'd2,
        ST_EDIT_S = 2'd3
    } state_t;

    // Counter address of the field a state edits; IDLE reports the seconds code.
    function automatic logic [1:0] field_of(input state_t s);
        case (s)
            ST_EDIT_H: field_of = ADDR_HOUR;
            ST_EDIT_M: field_of = ADDR_MIN;
            default:   field_of = ADDR_SEC;
        endcase
    endfunction

endpackage

// File: rtl/clk_set_ctrl_if.sv
// Button/counter-side bundle of the clock-setting controller.
// master = the controller, slave = the debouncers/counters/display side.
interface clk_set_ctrl_if #(parameter int DATA_W = clk_pkg::DATA_W);

    logic              tc_time_base;
    logic              btn_mode;
    logic              btn_up;
    logic              btn_down;
    logic [DATA_W-1:0] cur_sec;
    logic [DATA_W-1:0] cur_min;
    logic [DATA_W-1:0] cur_hour;
    logic              load;
    logic [1:0]        addrs;
    logic [DATA_W-1:0] data_in;
    logic              edit_active;
    logic [1:0]        edit_field;
    logic [DATA_W-1:0] edit_value;
    logic              blink;

    modport master (
        input  tc_time_base, btn_mode, btn_up, btn_down, cur_sec, cur_min, cur_hour,
        output load, addrs, data_in, edit_active, edit_field, edit_value, blink
    );

    modport slave (
        output tc_time_base, btn_mode, btn_up, btn_down, cur_sec, cur_min, cur_hour,
        input  load, addrs, data_in, edit_active, edit_field, edit_value, blink
    );

endinterface

// File: rtl/clk_set_ctrl_wrap_updown_cnt.sv
// Edit-value register: loadable seed (clamped to 0 when above max),
// +1/-1 with wrap in both directions against a runtime max.
module wrap_updown_cnt #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_seed,
    input  logic         i_inc,
    input  logic         i_dec,
    input  logic [W-1:0] i_max,
    output logic [W-1:0] o_value
);

    logic [W-1:0] r_val;

    // Load has priority; inc and dec together cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_val <= '0;
        end else if (i_load) begin
            r_val <= (i_seed > i_max) ? '0 : i_seed;
        end else if (i_inc && !i_dec) begin
            r_val <= (r_val >= i_max) ? '0 : r_val + W'(1);
        end else if (i_dec && !i_inc) begin
            r_val <= (r_val == '0 || r_val > i_max) ? i_max : r_val - W'(1);
        end
    end

    assign o_value = r_val;

endmodule

// File: rtl/clk_set_ctrl.sv
// Front-panel clock-setting controller: mode button walks hour -> minute ->
// second editing, committing each field to the counters with a one-cycle load.
// Editing aborts after TIMEOUT_TICKS seconds without a button press.
module clk_set_ctrl #(
    parameter int DATA_W        = clk_pkg::DATA_W,
    parameter int SEC_MAX       = clk_pkg::SEC_MAX,
    parameter int MIN_MAX       = clk_pkg::MIN_MAX,
    parameter int HOUR_MAX      = clk_pkg::HOUR_MAX,
    parameter int TIMEOUT_TICKS = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    clk_set_ctrl_if.master        bus
);
    import clk_pkg::*;

    localparam int TMO_W = $clog2(TIMEOUT_TICKS + 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [TMO_W-1:0]    r_tmo_cnt;
    logic                r_blink;
    logic                r_load;
    logic [1:0]          r_addrs;
    logic [DATA_W-1:0]   r_data_in;

    logic                w_any_btn;
    logic                w_expire;
    logic                w_issue;
    logic                w_cnt_load;
    logic [DATA_W-1:0]   w_seed;
    logic                w_inc;
    logic                w_dec;
    logic [DATA_W-1:0]   w_max;
    logic [DATA_W-1:0]   w_value;

    assign w_any_btn = bus.btn_mode | bus.btn_up | bus.btn_down;
    // A press in the expiring-tick cycle cancels the timeout.
    assign w_expire  = bus.tc_time_base && !w_any_btn &&
                       (r_tmo_cnt == TMO_W'(TIMEOUT_TICKS - 1));

    // Next state plus edit-value control; mode outranks up/down.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_cnt_load  = 1'b0;
        w_seed      = '0;
        w_inc       = 1'b0;
        w_dec       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.btn_mode) begin
                    w_state_nxt = ST_EDIT_H;
                    w_cnt_load  = 1'b1;
                    w_seed      = bus.cur_hour;
                end
            end
            default: begin
                if (bus.btn_mode) begin
                    w_issue    = 1'b1;
                    w_cnt_load = 1'b1;
                    case (r_state)
                        ST_EDIT_H: begin
                            w_state_nxt = ST_EDIT_M;
                            w_seed      = bus.cur_min;
                        end
                        ST_EDIT_M: begin
                            w_state_nxt = ST_EDIT_S;
                            w_seed      = bus.cur_sec;
                        end
                        default: w_state_nxt = ST_IDLE;
                    endcase
                end else if (w_expire) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_load  = 1'b1;
                end else begin
                    w_inc = bus.btn_up;
                    w_dec = bus.btn_down;
                end
            end
        endcase
    end

    // Limit of the field being edited next cycle; also clamps the seed on a field change.
    always_comb begin
        case (w_state_nxt)
            ST_EDIT_H: w_max = DATA_W'(HOUR_MAX);
            ST_EDIT_M: w_max = DATA_W'(MIN_MAX);
            ST_EDIT_S: w_max = DATA_W'(SEC_MAX);
            default:   w_max = '0;
        endcase
    end

    wrap_updown_cnt #(.W(DATA_W)) u_val (
        .clk     (clk),
        .rst_n   (reset),
        .i_load  (w_cnt_load),
        .i_seed  (w_seed),
        .i_inc   (w_inc),
        .i_dec   (w_dec),
        .i_max   (w_max),
        .o_value (w_value)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Timeout counter: cleared by any press or outside EDIT, counts ticks otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                r_tmo_cnt <= '0;
        else if (w_state_nxt == ST_IDLE || w_any_btn) r_tmo_cnt <= '0;
        else if (bus.tc_time_base)                 r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end

    // Blink: off in IDLE, on at EDIT entry, toggles per tick while editing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                     r_blink <= 1'b0;
        else if (w_state_nxt == ST_IDLE) r_blink <= 1'b0;
        else if (r_state == ST_IDLE)     r_blink <= 1'b1;
        else if (bus.tc_time_base)       r_blink <= ~r_blink;
    end

    // Commit strobe; address and data hold their last written value between loads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_load    <= 1'b0;
            r_addrs   <= ADDR_SEC;
            r_data_in <= '0;
        end else begin
            r_load <= w_issue;
            if (w_issue) begin
                r_addrs   <= field_of(r_state);
                r_data_in <= w_value;
            end
        end
    end

    assign bus.load        = r_load;
    assign bus.addrs       = r_addrs;
    assign bus.data_in     = r_data_in;
    assign bus.edit_active = (r_state != ST_IDLE);
    assign bus.edit_field  = field_of(r_state);
    assign bus.edit_value  = w_value;
    assign bus.blink       = r_blink;

endmodule
